dm_bus_arbiter: RTL and testbench

- Shares the single 128x16 data memory between two requesters: port 0 is the data cache miss path, port 1 is the instruction-fetch miss path (or a second cache).
- Serialises read and write transactions and forwards one at a time to the memory.
- Returns read data and per-port busy signals that stall the processor.
- Sits between the cache modules and the data memory, with round-robin fairness and a watchdog on memory latency.

---
 rtl/dm_bus_arbiter_pkg.sv | 14 +
 rtl/dm_bus_arbiter_if.sv | 25 ++
 rtl/dm_bus_arbiter_rr_arbiter2.sv | 15 +
 rtl/dm_bus_arbiter.sv | 107 ++++++++++
 tb/tb_dm_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg: shared state encoding, widths and command kinds for the data-memory arbiter
package dm_bus_arbiter_pkg;
   localparam int AW_DEF = 7;
   localparam int DW_DEF = 16;
   localparam logic KIND_READ  = 1'b0;
   localparam logic KIND_WRITE = 1'b1;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      DONE    = 3'd4
   } state_t;
endpackage

// File: rtl/dm_bus_arbiter_if.sv
// dm_bus_arbiter_if: two requester ports plus the memory side of the data-memory arbiter
interface dm_bus_arbiter_if
   import dm_bus_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          rd0, wr0, busy0, done0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0, rdata0;
   logic          rd1, wr1, busy1, done1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1, rdata1;
   logic          mem_read, mem_write, mem_wait, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   modport slave (
      input  rd0, wr0, addr0, wdata0, rd1, wr1, addr1, wdata1, mem_rdata, mem_wait,
      output rdata0, busy0, done0, rdata1, busy1, done1, mem_read, mem_write, mem_addr, mem_wdata, err
   );
   modport master (
      output rd0, wr0, addr0, wdata0, rd1, wr1, addr1, wdata1, mem_rdata, mem_wait,
      input  rdata0, busy0, done0, rdata1, busy1, done1, mem_read, mem_write, mem_addr, mem_wdata, err
   );
endinterface

// File: rtl/dm_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant with the last-served register (port 0 wins the first tie)
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       done_port,
   output logic       grant
);
   logic last;
   always_ff @(posedge clk or negedge reset)
      if (!reset) last <= 1'b1;
      else if (update) last <= done_port;
   assign grant = (&req) ? ~last : req[1];
endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: serialises two requesters onto one data memory with round-robin fairness and a latency watchdog
module dm_bus_arbiter
   import dm_bus_arbiter_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   dm_bus_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t        state, state_d;
   logic          kind_q, kind_g, kind_d, port_q, grant;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
   logic [CW-1:0] cnt;
   logic          req0, req1, in_wait, fin, tmo, cmd_d;
   logic          mem_read_q, mem_write_q, mem_read_d, mem_write_d;
   logic          done0_q, done1_q, done0_d, done1_d, err_q;

   assign req0    = bus.rd0 | bus.wr0;
   assign req1    = bus.rd1 | bus.wr1;
   assign kind_g  = (grant ? bus.rd1 : bus.rd0) ? KIND_READ : KIND_WRITE;
   assign in_wait = state == WAIT_HI || state == WAIT_LO;
   // a memory that never raises mem_wait is treated as done after two quiet cycles
   assign fin     = in_wait & ~bus.mem_wait & (state == WAIT_LO || cnt == CW'(1));
   assign tmo     = in_wait & bus.mem_wait & (cnt == CW'(TIMEOUT - 1));

   rr_arbiter2 u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       ({req1, req0}),
      .update    (state == DONE),
      .done_port (port_q),
      .grant     (grant)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_d;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = (req0 | req1) ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT_HI;
         WAIT_HI: state_d = (fin | tmo) ? DONE : bus.mem_wait ? WAIT_LO : WAIT_HI;
         WAIT_LO: state_d = (fin | tmo) ? DONE : WAIT_LO;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cmd_d       = state_d == ISSUE || state_d == WAIT_HI || state_d == WAIT_LO;
      kind_d      = (state == IDLE) ? kind_g : kind_q;
      mem_read_d  = cmd_d & (kind_d == KIND_READ);
      mem_write_d = cmd_d & (kind_d == KIND_WRITE);
      done0_d     = (state_d == DONE) & ~port_q;
      done1_d     = (state_d == DONE) & port_q;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         kind_q      <= KIND_READ;
         port_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         cnt         <= '0;
         err_q       <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
      end else begin
         if (state == IDLE && (req0 | req1)) begin
            kind_q  <= kind_g;
            port_q  <= grant;
            addr_q  <= grant ? bus.addr1 : bus.addr0;
            wdata_q <= grant ? bus.wdata1 : bus.wdata0;
         end
         if (fin && kind_q == KIND_READ && !port_q) rdata0_q <= bus.mem_rdata;
         if (fin && kind_q == KIND_READ && port_q) rdata1_q <= bus.mem_rdata;
         cnt         <= (state_d == ISSUE) ? '0 : in_wait ? cnt + 1'b1 : cnt;
         err_q       <= err_q | tmo;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
      end

   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.busy0     = reset & req0 & ~done0_q;
   assign bus.busy1     = reset & req1 & ~done1_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: vector table plus directed corner sequences for dm_bus_arbiter
module tb_dm_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;

   dm_bus_arbiter_if #(.AW(7), .DW(16)) b ();
   dm_bus_arbiter_if #(.AW(7), .DW(16)) bt ();
   dm_bus_arbiter dut (.clk(clk), .reset(reset), .bus(b));
   dm_bus_arbiter #(.TIMEOUT(20)) dut_to (.clk(clk), .reset(reset), .bus(bt));

   always #5 clk = ~clk;

   logic [15:0] mem [128];
   int  lat = 1;
   int  mcnt = 0;
   bit  active = 0;
   bit  completed = 0;

   task automatic mem_op();
      if (b.mem_read) b.mem_rdata = mem[b.mem_addr];
      else mem[b.mem_addr] = b.mem_wdata;
   endtask

   // memory model: raises mem_wait for lat cycles after a command appears
   always @(negedge clk) begin
      if (!(b.mem_read || b.mem_write)) begin
         active = 0;
         completed = 0;
         b.mem_wait = 1'b0;
      end else if (!active && !completed) begin
         if (lat == 0) begin
            completed = 1;
            mem_op();
         end else begin
            active = 1;
            mcnt = lat;
            b.mem_wait = 1'b1;
         end
      end else if (active) begin
         mcnt--;
         if (mcnt == 0) begin
            active = 0;
            completed = 1;
            b.mem_wait = 1'b0;
            mem_op();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit p, input bit rd, input bit wr, input logic [6:0] a, input logic [15:0] d);
      if (!p) begin
         b.rd0 = rd; b.wr0 = wr; b.addr0 = a; b.wdata0 = d;
      end else begin
         b.rd1 = rd; b.wr1 = wr; b.addr1 = a; b.wdata1 = d;
      end
   endtask

   function automatic logic bz(input bit p);
      return p ? b.busy1 : b.busy0;
   endfunction

   task automatic wait_done(input int limit, output logic [1:0] d);
      d = 2'b00;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (b.done0 || b.done1) begin
            d = {b.done1, b.done0};
            return;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(0, 0, 0, 7'h00, 16'h0);
      drive(1, 0, 0, 7'h00, 16'h0);
      bt.rd0 = 0; bt.wr0 = 0; bt.rd1 = 0; bt.wr1 = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      bit          port;
      bit          rd;
      bit          wr;
      logic [6:0]  addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t v[11];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [1:0]  d;
      logic [6:0]  a_seen;
      logic        k_seen;
      bit          seen;
      int          busy_bad, n, bad;
      for (int i = 0; i < 128; i++) mem[i] = 16'h0;
      mem[7'h11] = 16'hA5A5;
      b.mem_wait = 0; b.mem_rdata = 16'h0;
      bt.mem_wait = 1; bt.mem_rdata = 16'h0;
      bt.addr0 = 7'h44; bt.wdata0 = 0; bt.addr1 = 0; bt.wdata1 = 0;
      //       port rd wr addr   wdata     lat exp_rdata
      v[0]  = '{0, 1, 0, 7'h11, 16'h0000, 98, 16'hA5A5};
      v[1]  = '{1, 0, 1, 7'h20, 16'hBEEF, 3,  16'h0000};
      v[2]  = '{0, 1, 0, 7'h20, 16'h0000, 1,  16'hBEEF};
      v[3]  = '{1, 1, 0, 7'h11, 16'h0000, 5,  16'hA5A5};
      v[4]  = '{0, 0, 1, 7'h7F, 16'h0001, 2,  16'hBEEF};
      v[5]  = '{1, 1, 0, 7'h7F, 16'h0000, 0,  16'h0001};
      v[6]  = '{0, 1, 0, 7'h00, 16'h0000, 4,  16'h0000};
      v[7]  = '{1, 0, 1, 7'h11, 16'h5555, 0,  16'h0001};
      v[8]  = '{1, 1, 0, 7'h11, 16'h0000, 2,  16'h5555};
      v[9]  = '{0, 1, 1, 7'h11, 16'hFFFF, 2,  16'h5555};
      v[10] = '{1, 1, 0, 7'h11, 16'h0000, 1,  16'h5555};

      do_reset();
      reset = 1'b0;
      #1;
      chk("rst_rdata0", b.rdata0, 0);
      chk("rst_busy0", b.busy0, 0);
      chk("rst_done0", b.done0, 0);
      chk("rst_mem_read", b.mem_read, 0);
      chk("rst_mem_write", b.mem_write, 0);
      chk("rst_mem_addr", b.mem_addr, 0);
      chk("rst_err", b.err, 0);
      do_reset();

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         lat = v[i].lat;
         drive(v[i].port, v[i].rd, v[i].wr, v[i].addr, v[i].wdata);
         seen = 0; a_seen = 0; k_seen = 0; busy_bad = 0; d = 2'b00;
         #1 if (!bz(v[i].port)) busy_bad++;
         for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!seen && (b.mem_read || b.mem_write)) begin
               seen = 1; a_seen = b.mem_addr; k_seen = b.mem_write;
            end
            if (b.done0 || b.done1) begin
               d = {b.done1, b.done0};
               break;
            end
            if (!bz(v[i].port)) busy_bad++;
         end
         chk("vec_busy_hold", busy_bad, 0);
         chk("vec_busy_at_done", bz(v[i].port), 0);
         chk("vec_done_port", d, v[i].port ? 2'b10 : 2'b01);
         chk("vec_mem_addr", a_seen, v[i].addr);
         chk("vec_mem_kind", k_seen, v[i].wr & ~v[i].rd);
         chk("vec_rdata", v[i].port ? b.rdata1 : b.rdata0, v[i].exp_rdata);
         drive(v[i].port, 0, 0, 7'h00, 16'h0);
      end

      do_reset();
      @(negedge clk);
      lat = 3;
      drive(0, 1, 0, 7'h02, 16'h0);
      drive(1, 0, 1, 7'h03, 16'h1234);
      wait_done(100, d);
      chk("simul_first", d, 2'b01);
      chk("simul_rdata0", b.rdata0, 16'h0000);
      drive(0, 0, 0, 7'h00, 16'h0);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("done0_pulse", b.done0, 0);
         if (b.mem_write) break;
      end
      chk("simul_gap", n, 2);
      wait_done(100, d);
      chk("simul_second", d, 2'b10);
      chk("simul_mem3", mem[3], 16'h1234);
      drive(1, 0, 0, 7'h00, 16'h0);

      do_reset();
      @(negedge clk);
      lat = 2;
      drive(0, 1, 0, 7'h01, 16'h0);
      drive(1, 1, 0, 7'h02, 16'h0);
      for (int k = 0; k < 6; k++) begin
         wait_done(100, d);
         chk("rr_order", d, (k % 2) ? 2'b10 : 2'b01);
      end
      drive(0, 0, 0, 7'h00, 16'h0);
      drive(1, 0, 0, 7'h00, 16'h0);

      do_reset();
      @(negedge clk);
      lat = 10;
      drive(0, 1, 0, 7'h05, 16'h0);
      for (int k = 0; k < 10 && !b.mem_read; k++) @(negedge clk);
      @(negedge clk);
      b.addr0 = 7'h06;
      bad = 0;
      d = 2'b00;
      for (int k = 0; k < 100; k++) begin
         if (b.mem_read && b.mem_addr != 7'h05) bad++;
         @(negedge clk);
         if (b.done0 || b.done1) begin
            d = {b.done1, b.done0};
            break;
         end
      end
      chk("latch_addr", bad, 0);
      chk("latch_done", d, 2'b01);
      drive(0, 0, 0, 7'h00, 16'h0);

      do_reset();
      @(negedge clk);
      bt.rd0 = 1;
      for (int k = 0; k < 10 && !bt.mem_read; k++) @(negedge clk);
      n = 0;
      for (int k = 0; k < 100 && !bt.err; k++) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", n, 21);
      chk("to_done0", bt.done0, 1);
      chk("to_mem_read", bt.mem_read, 0);
      bt.rd0 = 0;
      repeat (5) @(negedge clk);
      chk("to_err_sticky", bt.err, 1);
      chk("to_rdata0", bt.rdata0, 0);
      chk("to_idle_cmd", bt.mem_read, 0);
      do_reset();
      #1 chk("to_err_cleared", bt.err, 0);

      @(negedge clk);
      lat = 50;
      drive(0, 1, 0, 7'h11, 16'h0);
      repeat (10) @(negedge clk);
      chk("pre_rst_mem_read", b.mem_read, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_mem_read", b.mem_read, 0);
      chk("arst_busy0", b.busy0, 0);
      chk("arst_done0", b.done0, 0);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 0, 7'h00, 16'h0);
      @(negedge clk);
      chk("arst_idle_cmd", b.mem_read, 0);
      lat = 2;
      drive(1, 1, 0, 7'h11, 16'h0);
      wait_done(100, d);
      chk("arst_port1_done", d, 2'b10);
      chk("arst_rdata1", b.rdata1, 16'h5555);
      drive(1, 0, 0, 7'h00, 16'h0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
